elevator_car_ctrl: RTL and testbench
====================================

// Module: elevator_car_ctrl
// PURPOSE
// - Parametrised single-car elevator controller: N floors, latched hall requests, SCAN ordering,
//   timed door, multi-cycle travel between adjacent floors.
// - Successor to the fixed 6-floor stepper. Adds request memory, direction hold/reverse,
//   door/travel timers and manual door close.
// - Sits between the request/keypad front end and the floor/door display logic.
// PARAMETERS
// - NUM_FLOORS     6  floors served, index 0 (bottom) .. NUM_FLOORS-1 (top); legal range 2..32
// - DOOR_CYCLES    4  cycles the door stays open per stop; >=1
// - TRAVEL_CYCLES  2  cycles to move one floor; >=1
// PORTS
// - clk            in   1           clock, all state on posedge
// - reset          in   1           synchronous, active-high
// - hall_req       in   NUM_FLOORS  request per floor, level or pulse; OR-ed into pending each cycle
// - door_close_req in   1           manual close; ends OPEN early
// - cur_floor      out  NUM_FLOORS  one-hot current floor
// - door_open      out  1           1 while in OPEN
// - moving         out  1           1 while in MOVE
// - dir_up         out  1           current/last travel direction, 1 = up
// - pending        out  NUM_FLOORS  latched, unserved requests
// BEHAVIOUR
// - Reset: all outputs registered and take their reset values at the edge where reset=1.
//   State IDLE; cur_floor=1 (floor 0); door_open=0; moving=0; dir_up=1; pending=0; timers=0.
//   Reset mid-MOVE or mid-OPEN jumps straight to floor 0 IDLE.
// - Effective request: req = pending | hall_req. Every decision uses req, so a same-cycle
//   hall_req is never lost.
// - ahead  = any req bit above cur_floor (dir_up=1) or below it (dir_up=0); behind = the opposite side.
// - here   = req bit at cur_floor.
// - States are IDLE, OPEN and MOVE.
// - IDLE:
//   - here -> OPEN: clear that pending bit; load the door timer with DOOR_CYCLES-1.
//   - else ahead -> MOVE.
//   - else behind -> MOVE and toggle dir_up.
//   - else stay in IDLE.
// - MOVE:
//   - The travel counter counts TRAVEL_CYCLES edges; on the last edge cur_floor shifts one
//     position in dir_up.
//   - Arrival edge: if the new floor is in req (including hall_req on that edge), go to OPEN on
//     the same edge and clear that bit. Otherwise stay in MOVE and reload the counter.
//   - Arriving at floor 0 or NUM_FLOORS-1 with no req there is impossible by construction.
//     Assert that cur_floor never shifts out of range.
// - OPEN:
//   - The door timer decrements each cycle. door_open is high for exactly DOOR_CYCLES cycles.
//   - hall_req at cur_floor: reload the timer; the bit is not latched.
//   - door_close_req: leave OPEN on the next edge.
//   - hall_req at cur_floor AND door_close_req in the same cycle: reopen wins and the timer reloads.
//   - Exit: ahead -> MOVE; else behind -> MOVE with dir_up toggled; else -> IDLE.
// - dir_up changes only on an IDLE->MOVE or OPEN->MOVE transition. At the top it can only go
//   down; at the bottom it can only go up.
// - pending bits are cleared only when their floor is served; there is no other way to clear them.
// - moving, door_open and the IDLE condition are mutually exclusive; exactly one cur_floor bit is set.
// STRUCTURE
// - elevator_pkg: state_t enum {IDLE,OPEN,MOVE}; floor_idx_t width $clog2(NUM_FLOORS);
//   timer width function.
// - Sub-module elev_scan_sel (combinational):
//   - inputs: cur_floor, req, dir_up
//   - outputs: here, ahead, behind
//   - implementation: above/below masks from the one-hot floor via (cur_floor-1) and ~((cur_floor<<1)-1).
// - Top level: FSM, two down-counters, pending register.
// TESTING (NUM_FLOORS=6, DOOR_CYCLES=4, TRAVEL_CYCLES=2)
// - Reset: hold reset=1 for 2 edges -> cur_floor=000001, door_open=0, moving=0, dir_up=1, pending=0.
// - Single trip: at IDLE floor 0, pulse hall_req=001000 on edge k ->
//   - edge k: moving=1, pending=001000
//   - edges k+2 / k+4 / k+6: cur_floor=000010 / 000100 / 001000
//   - edge k+6: door_open=1, pending=0
//   - edge k+10: IDLE
// - SCAN: moving up past floor 2, pulse hall_req=100010 -> car stops at floor 5 first, dir_up
//   flips to 0, then stops at floor 1; pending=0 at the end.
// - Door: in OPEN at floor 3, door_close_req=1 -> door_open=0 on the next edge.
//   Repeat with hall_req=001000 in the same cycle -> door_open stays high 4 more cycles.
// - Reversal and reset: at floor 5 with dir_up=1, request floor 0 -> dir_up=0 and the car
//   descends. Assert reset mid-descent -> floor 0, IDLE, pending=0 on that edge.
// - Sweep: at IDLE floor 0, hall_req=111111 for one cycle -> door opens at floors 0..5 in
//   ascending order, 4 cycles each, 2 travel cycles between; then IDLE at floor 5.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller.
//   state_t      : car FSM states
//   floor_idx_t  : binary floor index, wide enough for the largest legal car (32 floors)
//   tmr_w()      : width of a down-counter that is loaded with (cycles-1)
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        MOVE = 2'd2
    } state_t;

    localparam int MAX_FLOORS = 32;

    typedef logic [$clog2(MAX_FLOORS)-1:0] floor_idx_t;

    // Counter holds values 0..cycles-1; never narrower than one bit.
    function automatic int tmr_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/elev_scan_sel.sv
// Combinational SCAN selector.
//   cur_floor : one-hot current floor
//   req       : effective request vector (latched | same-cycle hall requests)
//   dir_up    : current travel direction, 1 = up
//   here      : a request exists at the current floor
//   ahead     : a request exists in the direction of travel
//   behind    : a request exists opposite to the direction of travel
module elev_scan_sel
#(
    parameter int NUM_FLOORS = 6
)(
    input  logic [NUM_FLOORS-1:0] cur_floor,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  dir_up,
    output logic                  here,
    output logic                  ahead,
    output logic                  behind
);

    localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

    logic [NUM_FLOORS-1:0] below_mask;
    logic [NUM_FLOORS-1:0] above_mask;
    logic                  any_below;
    logic                  any_above;

    // One-hot minus one sets every bit under the car. For the top floor the
    // shift drops the bit, so the subtraction wraps to all-ones and the
    // inverted above-mask correctly becomes empty.
    assign below_mask = cur_floor - ONE;
    assign above_mask = ~((cur_floor << 1) - ONE);

    assign any_below = |(req & below_mask);
    assign any_above = |(req & above_mask);

    assign here   = |(req & cur_floor);
    assign ahead  = dir_up ? any_above : any_below;
    assign behind = dir_up ? any_below : any_above;

endmodule

// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller with latched hall requests and SCAN ordering.
//   clk, reset       : clock; synchronous active-high reset
//   hall_req         : per-floor request, level or pulse, merged into pending
//   door_close_req   : manual close, ends the door-open period early
//   cur_floor        : one-hot current floor (floor 0 after reset)
//   door_open        : high while the door is open
//   moving           : high while travelling between floors
//   dir_up           : current / last travel direction, 1 = up
//   pending          : latched requests not yet served
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 6,
    parameter int DOOR_CYCLES   = 4,
    parameter int TRAVEL_CYCLES = 2
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] hall_req,
    input  logic                  door_close_req,
    output logic [NUM_FLOORS-1:0] cur_floor,
    output logic                  door_open,
    output logic                  moving,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int DW = tmr_w(DOOR_CYCLES);
    localparam int TW = tmr_w(TRAVEL_CYCLES);

    localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0] TRAV_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] D_ONE     = DW'(1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] cur_q, cur_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  dir_q, dir_d;
    logic [DW-1:0]         door_tmr_q, door_tmr_d;
    logic [TW-1:0]         trav_tmr_q, trav_tmr_d;
    logic                  door_open_q, door_open_d;
    logic                  moving_q, moving_d;

    logic [NUM_FLOORS-1:0] req;
    logic [NUM_FLOORS-1:0] nxt_floor;
    logic                  here, ahead, behind;
    logic                  trav_done, door_done;
    logic                  arr_hit, reopen, door_exit;

    // Same-cycle hall requests take part in every decision so none is lost.
    assign req       = pending_q | hall_req;
    assign nxt_floor = dir_q ? (cur_q << 1) : (cur_q >> 1);
    assign trav_done = (trav_tmr_q == '0);
    assign door_done = (door_tmr_q == '0);
    assign arr_hit   = |(req & nxt_floor);
    // A hall call at the open floor beats a manual close.
    assign reopen    = |(hall_req & cur_q);
    assign door_exit = !reopen && (door_done || door_close_req);

    elev_scan_sel #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_scan (
        .cur_floor (cur_q),
        .req       (req),
        .dir_up    (dir_q),
        .here      (here),
        .ahead     (ahead),
        .behind    (behind)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= NUM_FLOORS'(1);
            pending_q   <= '0;
            dir_q       <= 1'b1;
            door_tmr_q  <= '0;
            trav_tmr_q  <= '0;
            door_open_q <= 1'b0;
            moving_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            pending_q   <= pending_d;
            dir_q       <= dir_d;
            door_tmr_q  <= door_tmr_d;
            trav_tmr_q  <= trav_tmr_d;
            door_open_q <= door_open_d;
            moving_q    <= moving_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (here)                 state_d = OPEN;
                else if (ahead || behind) state_d = MOVE;
            end
            MOVE: begin
                if (trav_done && arr_hit) state_d = OPEN;
            end
            OPEN: begin
                if (door_exit) state_d = (ahead || behind) ? MOVE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output logic.
    always_comb begin
        cur_d      = cur_q;
        dir_d      = dir_q;
        pending_d  = req;
        door_tmr_d = door_tmr_q;
        trav_tmr_d = trav_tmr_q;
        unique case (state_q)
            IDLE: begin
                if (here) begin
                    pending_d  = req & ~cur_q;
                    door_tmr_d = DOOR_LOAD;
                end else if (ahead) begin
                    trav_tmr_d = TRAV_LOAD;
                end else if (behind) begin
                    trav_tmr_d = TRAV_LOAD;
                    dir_d      = ~dir_q;
                end
            end
            MOVE: begin
                if (trav_done) begin
                    cur_d = nxt_floor;
                    if (arr_hit) begin
                        pending_d  = req & ~nxt_floor;
                        door_tmr_d = DOOR_LOAD;
                    end else begin
                        trav_tmr_d = TRAV_LOAD;
                    end
                end else begin
                    trav_tmr_d = trav_tmr_q - T_ONE;
                end
            end
            OPEN: begin
                // Calls at the open floor are served by holding the door, not latched.
                pending_d = req & ~cur_q;
                if (reopen) begin
                    door_tmr_d = DOOR_LOAD;
                end else if (door_exit) begin
                    door_tmr_d = '0;
                    if (ahead) begin
                        trav_tmr_d = TRAV_LOAD;
                    end else if (behind) begin
                        trav_tmr_d = TRAV_LOAD;
                        dir_d      = ~dir_q;
                    end
                end else begin
                    door_tmr_d = door_tmr_q - D_ONE;
                end
            end
            default: ;
        endcase
        door_open_d = (state_d == OPEN);
        moving_d    = (state_d == MOVE);
    end

    assign cur_floor = cur_q;
    assign door_open = door_open_q;
    assign moving    = moving_q;
    assign dir_up    = dir_q;
    assign pending   = pending_q;

    // The car must never step past either end of the shaft.
    a_in_range: assert property (@(posedge clk) disable iff (reset)
        !(state_q == MOVE && trav_done && (dir_q ? cur_q[NUM_FLOORS-1] : cur_q[0])));

    a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(cur_q));

endmodule

// File: tb/tb_elevator_car_ctrl.sv
module tb_elevator_car_ctrl;

    localparam int NF = 6;
    localparam int DC = 4;
    localparam int TC = 2;

    localparam int M_IDLE = 0;
    localparam int M_OPEN = 1;
    localparam int M_MOVE = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] hall_req = '0;
    logic          door_close_req = 1'b0;
    logic [NF-1:0] cur_floor;
    logic          door_open;
    logic          moving;
    logic          dir_up;
    logic [NF-1:0] pending;

    int total = 0;
    int bad   = 0;

    // Reference model: integer floor, elapsed-cycle counts.
    int            m_floor = 0;
    int            m_st    = M_IDLE;
    bit            m_dir   = 1'b1;
    logic [NF-1:0] m_pend  = '0;
    int            m_door  = 0;
    int            m_trav  = 0;

    int stops[$];
    int open_len[$];
    int gap_len[$];

    elevator_car_ctrl #(
        .NUM_FLOORS    (NF),
        .DOOR_CYCLES   (DC),
        .TRAVEL_CYCLES (TC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .hall_req       (hall_req),
        .door_close_req (door_close_req),
        .cur_floor      (cur_floor),
        .door_open      (door_open),
        .moving         (moving),
        .dir_up         (dir_up),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit any_above(input logic [NF-1:0] r, input int f);
        for (int i = f + 1; i < NF; i++) if (r[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input logic [NF-1:0] r, input int f);
        for (int i = 0; i < f; i++) if (r[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int idx_of(input logic [NF-1:0] oh);
        for (int i = 0; i < NF; i++) if (oh[i]) return i;
        return -1;
    endfunction

    // One clock edge of the specified behaviour.
    task automatic model_edge(input logic [NF-1:0] h, input logic c, input logic r);
        logic [NF-1:0] req;
        bit ah, bh;
        if (r) begin
            m_floor = 0; m_st = M_IDLE; m_dir = 1'b1; m_pend = '0; m_door = 0; m_trav = 0;
            return;
        end
        req = m_pend | h;
        ah  = m_dir ? any_above(req, m_floor) : any_below(req, m_floor);
        bh  = m_dir ? any_below(req, m_floor) : any_above(req, m_floor);
        case (m_st)
            M_IDLE: begin
                if (req[m_floor]) begin
                    req[m_floor] = 1'b0; m_st = M_OPEN; m_door = 1;
                end else if (ah || bh) begin
                    if (!ah) m_dir = !m_dir;
                    m_st = M_MOVE; m_trav = 1;
                end
            end
            M_MOVE: begin
                if (m_trav < TC) m_trav++;
                else begin
                    m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                    if (req[m_floor]) begin
                        req[m_floor] = 1'b0; m_st = M_OPEN; m_door = 1;
                    end else m_trav = 1;
                end
            end
            default: begin
                req[m_floor] = 1'b0;
                if (h[m_floor]) m_door = 1;
                else if (c || m_door == DC) begin
                    if (ah || bh) begin
                        if (!ah) m_dir = !m_dir;
                        m_st = M_MOVE; m_trav = 1;
                    end else m_st = M_IDLE;
                end else m_door++;
            end
        endcase
        m_pend = req;
    endtask

    task automatic cmp_all();
        logic [NF-1:0] exp_cur;
        exp_cur = '0;
        exp_cur[m_floor] = 1'b1;
        chk("cur_floor", cur_floor, exp_cur);
        chk("door_open", door_open, m_st == M_OPEN);
        chk("moving", moving, m_st == M_MOVE);
        chk("dir_up", dir_up, m_dir);
        chk("pending", pending, m_pend);
    endtask

    // Drive at the falling edge, update the model at the rising edge, sample 1 unit later.
    task automatic step(input logic [NF-1:0] h, input logic c, input logic r);
        hall_req = h; door_close_req = c; reset = r;
        @(posedge clk);
        model_edge(h, c, r);
        #1;
        cmp_all();
        @(negedge clk);
    endtask

    // Idle the inputs until the car settles, logging stops, door time and travel gaps.
    task automatic run_collect(input int maxc);
        bit prev_open = 1'b0;
        bit done = 1'b0;
        int olen = 0;
        int mlen = 0;
        stops.delete(); open_len.delete(); gap_len.delete();
        for (int i = 0; i < maxc; i++) begin
            if (door_open && !prev_open) begin
                stops.push_back(idx_of(cur_floor));
                if (stops.size() > 1) gap_len.push_back(mlen);
            end
            if (!door_open && prev_open) begin
                open_len.push_back(olen); olen = 0; mlen = 0;
            end
            if (door_open) olen++;
            if (moving) mlen++;
            prev_open = door_open;
            if (!door_open && !moving) begin done = 1'b1; break; end
            step('0, 1'b0, 1'b0);
        end
        chk("settled", done, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        // Reset
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        chk("rst_cur", cur_floor, 6'b000001);
        chk("rst_door", door_open, 1'b0);
        chk("rst_mov", moving, 1'b0);
        chk("rst_dir", dir_up, 1'b1);
        chk("rst_pend", pending, 6'b000000);

        // Single trip to floor 3
        step(6'b001000, 1'b0, 1'b0);
        chk("trip_mov", moving, 1'b1);
        chk("trip_pend", pending, 6'b001000);
        repeat (2) step('0, 1'b0, 1'b0);
        chk("trip_f1", cur_floor, 6'b000010);
        repeat (2) step('0, 1'b0, 1'b0);
        chk("trip_f2", cur_floor, 6'b000100);
        repeat (2) step('0, 1'b0, 1'b0);
        chk("trip_f3", cur_floor, 6'b001000);
        chk("trip_open", door_open, 1'b1);
        chk("trip_pend0", pending, 6'b000000);
        repeat (4) step('0, 1'b0, 1'b0);
        chk("trip_idle", {door_open, moving}, 2'b00);

        // Door: manual close, then close overridden by a same-floor call
        step(6'b001000, 1'b0, 1'b0);
        chk("door_op", door_open, 1'b1);
        step('0, 1'b1, 1'b0);
        chk("door_close", door_open, 1'b0);
        step(6'b001000, 1'b0, 1'b0);
        step(6'b001000, 1'b1, 1'b0);
        chk("door_reopen", door_open, 1'b1);
        repeat (3) begin
            step('0, 1'b0, 1'b0);
            chk("door_hold", door_open, 1'b1);
        end
        step('0, 1'b0, 1'b0);
        chk("door_end", door_open, 1'b0);

        // SCAN: top stop first, then reverse to floor 1
        step('0, 1'b0, 1'b1);
        step(6'b100000, 1'b0, 1'b0);
        repeat (4) step('0, 1'b0, 1'b0);
        chk("scan_f2", cur_floor, 6'b000100);
        step(6'b100010, 1'b0, 1'b0);
        run_collect(80);
        chk("scan_nstop", stops.size(), 2);
        chk("scan_s0", (stops.size() > 0) ? stops[0] : -1, 5);
        chk("scan_s1", (stops.size() > 1) ? stops[1] : -1, 1);
        chk("scan_dir", dir_up, 1'b0);
        chk("scan_pend", pending, 6'b000000);

        // Sweep: all floors from floor 0
        step('0, 1'b0, 1'b1);
        step(6'b111111, 1'b0, 1'b0);
        run_collect(120);
        chk("sweep_nstop", stops.size(), NF);
        for (int i = 0; i < NF; i++) begin
            chk("sweep_order", (stops.size() > i) ? stops[i] : -1, i);
            chk("sweep_open", (open_len.size() > i) ? open_len[i] : -1, DC);
        end
        for (int i = 0; i < NF - 1; i++)
            chk("sweep_gap", (gap_len.size() > i) ? gap_len[i] : -1, TC);
        chk("sweep_end", cur_floor, 6'b100000);
        chk("sweep_dir", dir_up, 1'b1);

        // Reversal from the top, then reset mid-descent
        step(6'b000001, 1'b0, 1'b0);
        chk("rev_dir", dir_up, 1'b0);
        chk("rev_mov", moving, 1'b1);
        repeat (3) step('0, 1'b0, 1'b0);
        chk("rev_f4", cur_floor, 6'b010000);
        step('0, 1'b0, 1'b1);
        chk("rev_rst_cur", cur_floor, 6'b000001);
        chk("rev_rst_st", {door_open, moving}, 2'b00);
        chk("rev_rst_pend", pending, 6'b000000);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic [NF-1:0] h;
            logic c, r;
            h = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
            c = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 399) == 0);
            step(h, c, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
